// File: rtl/bn_pkg.sv
// Shared types and defaults for the batchnorm stream sequencer.
package bn_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } bn_ctrl_state_t;

  localparam int BN_LATENCY_DEFAULT = 5;

  // Fixed-point 1.0 with frac fractional bits.
  function automatic int BN_UNITY(input int frac);
    return 1 << frac;
  endfunction
endpackage

// File: rtl/bn_out_fifo.sv
// First-word-fall-through result FIFO; push and pop may coincide, even when full.
module bn_out_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty reads present zero rather than stale storage.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // NOTE: combinational next-state uses blocking '=' with a default for every
  // signal first, so no latch is inferred; flops below use non-blocking '<='.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CNW'(do_push) - CNW'(do_pop);
  end

  // NOTE: storage is deliberately not reset; count_q alone defines which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bn_stream_ctrl.sv
// Per-layer batchnorm sequencer: clear, load gamma/beta, arm, stream one frame,
// and collect results into a credit-protected output FIFO.
module bn_stream_ctrl
  import bn_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int CHANNELS   = 16,
  parameter int PIXELS     = 64,
  parameter int BN_LATENCY = BN_LATENCY_DEFAULT,
  parameter int OUT_DEPTH  = 8,
  localparam int CW        = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      param_valid,
  output logic                      param_ready,
  input  logic [WIDTH-1:0]          param_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      bn_rst,
  output logic                      bn_en,
  output logic                      bn_valid,
  output logic [WIDTH-1:0]          bn_x,
  output logic [CW-1:0]             bn_channel,
  output logic [CHANNELS*WIDTH-1:0] gamma_packed,
  output logic [CHANNELS*WIDTH-1:0] beta_packed,
  input  logic [WIDTH-1:0]          bn_y,
  input  logic [CW-1:0]             bn_channel_out,
  input  logic                      bn_valid_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_channel,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int TOTAL = PIXELS * CHANNELS;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(2 * CHANNELS);
  localparam int FW    = $clog2(OUT_DEPTH) + 1;
  // Headroom for a full batchnorm pipeline on top of the FIFO depth.
  localparam int NW    = $clog2(OUT_DEPTH + BN_LATENCY + 1);
  localparam logic [WIDTH-1:0] UNITY = WIDTH'(BN_UNITY(FRAC));

  bn_ctrl_state_t            state_q, state_d;
  logic                      bn_rst_q, bn_rst_d, bn_en_q, bn_en_d;
  logic                      bn_valid_q, bn_valid_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0]          bn_x_q, bn_x_d;
  logic [CW-1:0]             bn_ch_q, bn_ch_d, ch_cnt_q, ch_cnt_d, exp_ch_q, exp_ch_d;
  logic [CHANNELS*WIDTH-1:0] gamma_q, gamma_d, beta_q, beta_d;
  logic [PW-1:0]             param_cnt_q, param_cnt_d;
  logic                      arm_cnt_q, arm_cnt_d;
  logic [IW-1:0]             issued_q, issued_d;
  logic [NW-1:0]             inflight_q, inflight_d;

  logic [FW-1:0]             fifo_count;
  logic                      fifo_full, fifo_empty;
  logic [CW+WIDTH-1:0]       fifo_rd;
  logic                      credit_ok, fire_in, fire_param, pop, ret_ok, drop;

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    return (c == CW'(CHANNELS - 1)) ? '0 : c + CW'(1);
  endfunction

  assign credit_ok   = (int'(fifo_count) + int'(inflight_q)) < OUT_DEPTH;
  assign in_ready    = (state_q == ST_RUN) && credit_ok && (issued_q < IW'(TOTAL));
  assign param_ready = (state_q == ST_LOAD);
  assign fire_in     = in_valid && in_ready;
  assign fire_param  = param_valid && param_ready;
  assign pop         = out_ready && !fifo_empty;
  assign ret_ok      = bn_valid_out && (inflight_q != '0);
  assign drop        = bn_valid_out && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    bn_valid_d  = 1'b0;
    bn_x_d      = bn_x_q;
    bn_ch_d     = bn_ch_q;
    done_d      = 1'b0;
    gamma_d     = gamma_q;
    beta_d      = beta_q;
    param_cnt_d = param_cnt_q;
    arm_cnt_d   = arm_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    issued_d    = issued_q;
    inflight_d  = inflight_q;
    exp_ch_d    = exp_ch_q;
    err_d       = err_q;

    if (fire_in && !ret_ok)      inflight_d = inflight_q + NW'(1);
    else if (ret_ok && !fire_in) inflight_d = inflight_q - NW'(1);

    if (bn_valid_out) begin
      exp_ch_d = next_ch(exp_ch_q);
      if ((bn_channel_out != exp_ch_q) || (inflight_q == '0) || drop) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (start) begin
        state_d     = ST_CLR;
        err_d       = 1'b0;
        param_cnt_d = '0;
        ch_cnt_d    = '0;
        issued_d    = '0;
        inflight_d  = '0;
        exp_ch_d    = '0;
      end
      ST_CLR: state_d = ST_LOAD;
      ST_LOAD: if (fire_param) begin
        if (int'(param_cnt_q) < CHANNELS)
          gamma_d[int'(param_cnt_q)*WIDTH +: WIDTH] = param_data;
        else
          beta_d[(int'(param_cnt_q) - CHANNELS)*WIDTH +: WIDTH] = param_data;
        param_cnt_d = param_cnt_q + PW'(1);
        if (param_cnt_q == PW'(2 * CHANNELS - 1)) begin
          state_d   = ST_ARM;
          arm_cnt_d = 1'b0;
        end
      end
      ST_ARM: begin
        arm_cnt_d = ~arm_cnt_q;
        if (arm_cnt_q) state_d = ST_RUN;
      end
      ST_RUN: if (fire_in) begin
        bn_valid_d = 1'b1;
        bn_x_d     = in_data;
        bn_ch_d    = ch_cnt_q;
        ch_cnt_d   = next_ch(ch_cnt_q);
        issued_d   = issued_q + IW'(1);
        if (issued_q == IW'(TOTAL - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if ((inflight_q == '0) && fifo_empty) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bn_rst_d = (state_d == ST_CLR);
    bn_en_d  = (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bn_rst_q    <= 1'b1;
      bn_en_q     <= 1'b0;
      bn_valid_q  <= 1'b0;
      bn_x_q      <= '0;
      bn_ch_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      gamma_q     <= {CHANNELS{UNITY}};
      beta_q      <= '0;
      param_cnt_q <= '0;
      arm_cnt_q   <= 1'b0;
      ch_cnt_q    <= '0;
      issued_q    <= '0;
      inflight_q  <= '0;
      exp_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      bn_rst_q    <= bn_rst_d;
      bn_en_q     <= bn_en_d;
      bn_valid_q  <= bn_valid_d;
      bn_x_q      <= bn_x_d;
      bn_ch_q     <= bn_ch_d;
      done_q      <= done_d;
      err_q       <= err_d;
      gamma_q     <= gamma_d;
      beta_q      <= beta_d;
      param_cnt_q <= param_cnt_d;
      arm_cnt_q   <= arm_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      exp_ch_q    <= exp_ch_d;
    end
  end

  bn_out_fifo #(
    .DATA_W(CW + WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bn_valid_out),
    .push_data({bn_channel_out, bn_y}),
    .pop      (pop),
    .rd_data  (fifo_rd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_rd[WIDTH-1:0];
  assign out_channel  = fifo_rd[CW+WIDTH-1:WIDTH];
  assign bn_rst       = bn_rst_q;
  assign bn_en        = bn_en_q;
  assign bn_valid     = bn_valid_q;
  assign bn_x         = bn_x_q;
  assign bn_channel   = bn_ch_q;
  assign gamma_packed = gamma_q;
  assign beta_packed  = beta_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: doc/bn_stream_ctrl.md
# bn_stream_ctrl

Sequencer that owns the per-layer batchnorm datapath: on `start` it clears the batchnorm instance, streams `2*CHANNELS` gamma/beta words into packed parameter registers, arms the unit, then issues one frame of channel-interleaved activations (`PIXELS*CHANNELS` words) with correct channel tags. Results are collected into a backpressurable output FIFO using credit-based flow control against the fixed batchnorm latency. It sits between the depthwise/pointwise conv output stream and the activation stage of each bottleneck.

## Interface
- `WIDTH`, 16, data/parameter word width
- `FRAC`, 8, fractional bits; unity gamma = `1<<FRAC`
- `CHANNELS`, 16, channels per pixel; `CW = $clog2(CHANNELS)`
- `PIXELS`, 64, pixels per frame
- `BN_LATENCY`, 5, batchnorm cycles from `bn_valid` to `bn_valid_out`
- `OUT_DEPTH`, 8, output FIFO depth (power of 2); full throughput when `OUT_DEPTH >= BN_LATENCY+1`

Clocking: one clock, `clk`; reset `rst` is asynchronous and active-high.

- `clk` in 1: clock
- `rst` in 1: async active-high reset
- `start` in 1: 1-cycle pulse, begins a frame; ignored unless IDLE
- `param_valid`/`param_ready` in/out 1: parameter word handshake
- `param_data` in WIDTH: gamma[0..CHANNELS-1], then beta[0..CHANNELS-1]
- `in_valid`/`in_ready` in/out 1: activation handshake
- `in_data` in WIDTH: activation word, channel order 0..CHANNELS-1 per pixel
- `bn_rst`, `bn_en`, `bn_valid` out 1: batchnorm control
- `bn_x` out WIDTH; `bn_channel` out CW: batchnorm input
- `gamma_packed`, `beta_packed` out CHANNELS*WIDTH: parameter registers
- `bn_y` in WIDTH; `bn_channel_out` in CW; `bn_valid_out` in 1: batchnorm result
- `out_valid`/`out_ready` out/in 1; `out_data` out WIDTH; `out_channel` out CW: result stream
- `busy` out 1: state != IDLE
- `done` out 1: 1-cycle pulse at frame completion
- `err` out 1: sticky error, cleared on `start`

## Operation
- States: IDLE -> CLR -> LOAD -> ARM -> RUN -> DRAIN -> IDLE.
- IDLE: `start` clears `err` and all counters, then goes to CLR.
- CLR (1 cycle): `bn_rst=1`, then LOAD.
- LOAD: `param_ready=1`. Word k is written to `gamma_packed[k*WIDTH+:WIDTH]` for k<CHANNELS, else to `beta_packed[(k-CHANNELS)*WIDTH+:WIDTH]`. After word `2*CHANNELS-1` is accepted, go to ARM.
- ARM (2 cycles): `bn_en=1`, `bn_valid=0`. Covers batchnorm memory init and parameter latch. Then RUN.
- RUN: `in_ready = (credit>0) && (issued < PIXELS*CHANNELS)`.
  - On accept: `bn_valid=1`, `bn_x=in_data`, `bn_channel=ch_cnt`.
  - `ch_cnt` wraps CHANNELS-1 -> 0; `issued` increments.
  - After the last issue, go to DRAIN.
- `bn_en=1` throughout ARM, RUN and DRAIN.
- Credit: `credit = OUT_DEPTH - fifo_count - inflight`.
  - `inflight` +1 on issue, -1 on `bn_valid_out`; on a simultaneous issue and return it is unchanged.
  - `bn_valid_out` pushes `{bn_channel_out, bn_y}` into the FIFO.
- Check: `exp_ch` counts returns and wraps at CHANNELS. `err` is set on any of:
  - `bn_channel_out != exp_ch`;
  - `bn_valid_out` while `inflight==0`;
  - `bn_valid_out` while FIFO full (the word is dropped).
- DRAIN: when `inflight==0` and the FIFO is empty, pulse `done` and return to IDLE.
- Outputs `bn_valid`, `bn_x` and `bn_channel` are registered.

## Timing
- Reset values: `bn_rst=1`; all other outputs are 0, except `gamma_packed` (every word `1<<FRAC`) and `beta_packed` (0). FIFO is empty.
  - `bn_rst` drops on the first clock after `rst` deasserts.
- Issue latency: `in_valid&&in_ready` at edge n gives `bn_valid=1` in cycle n+1.
- Output latency: FIFO is first-word-fall-through. A result arriving at edge m with the FIFO empty shows `out_valid=1` in cycle m+1.
- FIFO push and pop in the same cycle are both allowed, including when full. Pointers wrap modulo OUT_DEPTH.
- Parameters change only in LOAD and hold their values until the next LOAD.
- `rst` mid-frame: immediate return to reset values, and in-flight data is discarded.
- Frame time with no backpressure: `1 + 2*CHANNELS + 2 + PIXELS*CHANNELS + BN_LATENCY + 1` cycles minimum.

## Structure
- Shared package `bn_pkg`:
  - state enum `bn_ctrl_state_t`;
  - `BN_UNITY(FRAC)` constant function;
  - default `BN_LATENCY`.
- One sub-module, `bn_out_fifo`: synchronous FWFT FIFO with parameters WIDTH+CW and OUT_DEPTH, exposing count, full and empty.

## Test plan
- Load gamma=0x0200, beta=0x0010 for all channels; 1 pixel, CHANNELS=4, input 0x0100 -> 4 outputs 0x0210 with `out_channel` 0,1,2,3; `done` 1 cycle later; `err=0`.
- Full frame with `out_ready=0`: exactly OUT_DEPTH words are issued, `in_ready` stays 0, no drop; release -> all `PIXELS*CHANNELS` words arrive in order.
- Model returns `bn_channel_out=2` when 1 is expected -> `err=1` and stays 1; next `start` clears it.
- `start` pulsed during RUN -> ignored, frame count unchanged; `start` during IDLE -> `bn_rst` high exactly 1 cycle, then `param_ready`.
- Assert `rst` in RUN with inflight=3 -> all outputs at reset values the same cycle, FIFO empty, `busy=0`.
- `param_valid` toggling every other cycle -> exactly 2*CHANNELS words stored, in order, checked against `gamma_packed`/`beta_packed`.
